// File: rtl/des_perm_pipe.sv
// des_perm_pipe: per-beat selectable DES bit permutation (identity, IP, FP,
// swap-then-FP) on LANES 64-bit blocks, followed by STAGES registered stages
// with full valid/ready backpressure and synchronous flush.
// Optional output-handshake counter enabled by defining DES_PERM_STATS_EN.
module des_perm_pipe #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [64*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_mode,
  output logic [64*LANES-1:0]   out_data,
  output logic                  busy
`ifdef DES_PERM_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_cnt
`endif
);

  localparam int unsigned DW = 64 * LANES;

  // Initial permutation; bit 1 is d[63]. Row r of the table starts at
  // 58,60,62,64,57,59,61,63 and each column steps the source down by 8.
  function automatic logic [63:0] ip64(input logic [63:0] d);
    logic [63:0] r;
    int unsigned row, col, src;
    r = '0;
    for (int unsigned p = 0; p < 64; p++) begin
      row = p / 8;
      col = p % 8;
      src = ((row < 4) ? (58 + 2 * row) : (49 + 2 * row)) - 8 * col;
      r[6'(63 - p)] = d[6'(64 - src)];
    end
    return r;
  endfunction

  // Final permutation (inverse of IP): even columns start at 40, odd at 8,
  // each column pair adds 8 and each row subtracts 1.
  function automatic logic [63:0] fp64(input logic [63:0] d);
    logic [63:0] r;
    int unsigned row, col, src;
    r = '0;
    for (int unsigned p = 0; p < 64; p++) begin
      row = p / 8;
      col = p % 8;
      src = (((col % 2) == 0) ? 40 : 8) + 8 * (col / 2) - row;
      r[6'(63 - p)] = d[6'(64 - src)];
    end
    return r;
  endfunction

  function automatic logic [63:0] perm_lane(input logic [1:0] m, input logic [63:0] d);
    logic [63:0] r;
    case (m)
      2'b01:   r = ip64(d);
      2'b10:   r = fp64(d);
      2'b11:   r = fp64({d[31:0], d[63:32]});
      default: r = d;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [1:0]        mode_q [STAGES];
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     perm_in;

  // Combinational permutation of every lane at the stage-0 input
  always_comb begin
    perm_in = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      perm_in[64*k +: 64] = perm_lane(in_mode, in_data[64*k +: 64]);
    end
  end

  // A stage may advance if it or any stage downstream is empty, or the sink takes a beat
  always_comb begin
    logic acc;
    adv = '0;
    acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | !vld[i];
      adv[i] = acc;
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign out_valid = vld[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |vld;

  // Pipeline registers; payload only loads when a valid beat moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        mode_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          mode_q[0] <= in_mode;
          data_q[0] <= perm_in;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            mode_q[i] <= mode_q[i-1];
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

`ifdef DES_PERM_STATS_EN
  // Saturating count of output handshakes; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (stat_clr) begin
      stat_cnt <= '0;
    end else if (out_valid && out_ready && (stat_cnt != 32'hFFFF_FFFF)) begin
      stat_cnt <= stat_cnt + 32'd1;
    end
  end
`endif

endmodule
